// File: rtl/pa_stream_responder.sv
// pa_stream_responder: far end of the PA sequencer weight, data and result handshakes.
// It holds three circular FIFOs:
//   - the weight and data FIFOs are filled by the host and drained by the sequencer;
//   - the result FIFO is filled by the PA array and drained by the host.
// Each result is stored with its result_addr tag, and the tag sequence is checked mod 16.
// Optional build macro: PA_RESP_STATS_EN adds the transfer counters stat_w, stat_d and stat_r.

module pa_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             counter_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             ovf,
  output logic             unf
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             full, empty, do_push, do_pop;

  // Full and empty come from the level registered at cycle start,
  // so a pop never makes room for a push in the same cycle.
  always_comb begin
    full    = (level == FULL_LVL);
    empty   = (level == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    ovf     = push & full;
    unf     = pop & empty;
    rdata   = empty ? '0 : mem[rptr];
  end

  // Storage write; the contents are unreset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and level; the pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module pa_stream_responder #(
  parameter int W_W   = 32,
  parameter int D_W   = 32,
  parameter int R_W   = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic           clk,
  input  logic           counter_rst_n,
  input  logic           w_push,
  input  logic [W_W-1:0] w_wdata,
  input  logic           d_push,
  input  logic [D_W-1:0] d_wdata,
  output logic           weight_rd_rdy,
  input  logic           weight_rd_acq,
  output logic [W_W-1:0] weight_rd_data,
  output logic           data_rd_rdy,
  input  logic           data_rd_acq,
  output logic [D_W-1:0] data_rd_data,
  input  logic           dst_wr_rdy,
  output logic           dst_wr_acq,
  input  logic [R_W-1:0] dst_wr_data,
  input  logic [3:0]     result_addr,
  input  logic           r_pop,
  output logic [R_W+3:0] r_rdata,
  output logic           r_valid,
  output logic [AW:0]    w_level,
  output logic [AW:0]    d_level,
  output logic [AW:0]    r_level,
  output logic [2:0]     err
`ifdef PA_RESP_STATS_EN
  ,
  output logic [31:0]    stat_w,
  output logic [31:0]    stat_d,
  output logic [31:0]    stat_r
`endif
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic       w_ovf, w_unf, d_ovf, d_unf, r_ovf, r_unf;
  logic [3:0] exp_tag;
  logic       seq_bad;

  pa_resp_fifo #(.WIDTH(W_W), .DEPTH(DEPTH), .AW(AW)) u_wfifo (
    .clk(clk), .counter_rst_n(counter_rst_n), .push(w_push), .wdata(w_wdata),
    .pop(weight_rd_acq), .rdata(weight_rd_data), .level(w_level),
    .ovf(w_ovf), .unf(w_unf));

  pa_resp_fifo #(.WIDTH(D_W), .DEPTH(DEPTH), .AW(AW)) u_dfifo (
    .clk(clk), .counter_rst_n(counter_rst_n), .push(d_push), .wdata(d_wdata),
    .pop(data_rd_acq), .rdata(data_rd_data), .level(d_level),
    .ovf(d_ovf), .unf(d_unf));

  pa_resp_fifo #(.WIDTH(R_W+4), .DEPTH(DEPTH), .AW(AW)) u_rfifo (
    .clk(clk), .counter_rst_n(counter_rst_n), .push(dst_wr_acq),
    .wdata({result_addr, dst_wr_data}), .pop(r_pop), .rdata(r_rdata),
    .level(r_level), .ovf(r_ovf), .unf(r_unf));

  // Handshake status. A full result FIFO stalls the PA instead of dropping the result.
  always_comb begin
    weight_rd_rdy = (w_level != '0);
    data_rd_rdy   = (d_level != '0);
    r_valid       = (r_level != '0);
    dst_wr_acq    = dst_wr_rdy & (r_level != FULL_LVL);
    seq_bad       = dst_wr_acq & (result_addr != exp_tag);
  end

  // Expected tag follows the accepted stream and resyncs after a mismatch.
  // Error flags are sticky until reset.
  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      exp_tag <= '0;
      err     <= '0;
    end else begin
      if (dst_wr_acq) exp_tag <= result_addr + 4'd1;
      err <= err | {seq_bad, w_ovf | d_ovf | r_ovf, w_unf | d_unf | r_unf};
    end
  end

`ifdef PA_RESP_STATS_EN
  // Transfer counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge counter_rst_n) begin
    if (!counter_rst_n) begin
      stat_w <= '0;
      stat_d <= '0;
      stat_r <= '0;
    end else begin
      if (weight_rd_rdy & weight_rd_acq) stat_w <= stat_w + 32'd1;
      if (data_rd_rdy & data_rd_acq)     stat_d <= stat_d + 32'd1;
      if (dst_wr_acq)                    stat_r <= stat_r + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pa_stream_responder.sv
// Directed bench for pa_stream_responder.
// A vector table exercises the weight FIFO; hand sequences cover the fill, stall, sequence-check and reset cases.
module tb_pa_stream_responder;
  logic        clk = 1'b0;
  logic        counter_rst_n;
  logic        w_push, d_push, weight_rd_acq, data_rd_acq, dst_wr_rdy, r_pop;
  logic [31:0] w_wdata, d_wdata, dst_wr_data;
  logic [3:0]  result_addr;
  logic        weight_rd_rdy, data_rd_rdy, dst_wr_acq, r_valid;
  logic [31:0] weight_rd_data, data_rd_data;
  logic [35:0] r_rdata;
  logic [4:0]  w_level, d_level, r_level;
  logic [2:0]  err;
`ifdef PA_RESP_STATS_EN
  logic [31:0] stat_w, stat_d, stat_r;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pa_stream_responder dut (
    .clk(clk), .counter_rst_n(counter_rst_n),
    .w_push(w_push), .w_wdata(w_wdata), .d_push(d_push), .d_wdata(d_wdata),
    .weight_rd_rdy(weight_rd_rdy), .weight_rd_acq(weight_rd_acq), .weight_rd_data(weight_rd_data),
    .data_rd_rdy(data_rd_rdy), .data_rd_acq(data_rd_acq), .data_rd_data(data_rd_data),
    .dst_wr_rdy(dst_wr_rdy), .dst_wr_acq(dst_wr_acq), .dst_wr_data(dst_wr_data),
    .result_addr(result_addr), .r_pop(r_pop), .r_rdata(r_rdata), .r_valid(r_valid),
    .w_level(w_level), .d_level(d_level), .r_level(r_level), .err(err)
`ifdef PA_RESP_STATS_EN
    , .stat_w(stat_w), .stat_d(stat_d), .stat_r(stat_r)
`endif
  );

  typedef struct {
    logic        push;
    logic [31:0] wd;
    logic        acq;
    logic [4:0]  lvl;
    logic        rdy;
    logic [31:0] head;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_push = 0; d_push = 0; weight_rd_acq = 0; data_rd_acq = 0;
    dst_wr_rdy = 0; r_pop = 0; w_wdata = 0; d_wdata = 0;
    dst_wr_data = 0; result_addr = 0;
  endtask

  task automatic do_reset();
    idle();
    counter_rst_n = 0;
    #2;
    counter_rst_n = 1;
    tick();
  endtask

  initial begin
    vt[0] = '{1'b1, 32'h11, 1'b0, 5'd1, 1'b1, 32'h11};
    vt[1] = '{1'b1, 32'h22, 1'b0, 5'd2, 1'b1, 32'h11};
    vt[2] = '{1'b1, 32'h33, 1'b1, 5'd2, 1'b1, 32'h22};
    vt[3] = '{1'b0, 32'h00, 1'b1, 5'd1, 1'b1, 32'h33};
    vt[4] = '{1'b0, 32'h00, 1'b1, 5'd0, 1'b0, 32'h00};
    vt[5] = '{1'b1, 32'h44, 1'b0, 5'd1, 1'b1, 32'h44};
    vt[6] = '{1'b0, 32'h00, 1'b1, 5'd0, 1'b0, 32'h00};

    // Reset state
    idle();
    counter_rst_n = 0;
    #12;
    chk("rst_w_level", w_level, 0);
    chk("rst_d_level", d_level, 0);
    chk("rst_r_level", r_level, 0);
    chk("rst_flags", {weight_rd_rdy, data_rd_rdy, r_valid, dst_wr_acq}, 0);
    chk("rst_err", err, 0);
    chk("rst_r_rdata", r_rdata, 0);
    counter_rst_n = 1;
    tick();

    // Table-driven weight FIFO vectors
    foreach (vt[i]) begin
      w_push = vt[i].push;
      w_wdata = vt[i].wd;
      weight_rd_acq = vt[i].acq;
      tick();
      chk($sformatf("vec%0d_level", i), w_level, vt[i].lvl);
      chk($sformatf("vec%0d_rdy", i), weight_rd_rdy, vt[i].rdy);
      chk($sformatf("vec%0d_head", i), weight_rd_data, vt[i].head);
    end
    idle();
    chk("vec_err", err, 0);

    // 16 weights streamed with acq held high
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w_push = 1;
      w_wdata = i;
      tick();
    end
    w_push = 0;
    chk("w_fill_level", w_level, 16);
    weight_rd_acq = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("w_stream_%0d", i), {weight_rd_rdy, weight_rd_data}, {1'b1, 32'(i)});
      tick();
    end
    weight_rd_acq = 0;
    chk("w_stream_rdy_drop", weight_rd_rdy, 0);
    chk("w_stream_err", err, 0);
`ifdef PA_RESP_STATS_EN
    chk("stat_w16", stat_w, 16);
`endif

    // Data FIFO overflow: the 17th word is dropped
    do_reset();
    for (int i = 0; i < 17; i++) begin
      d_push = 1;
      d_wdata = (i == 16) ? 32'h999 : 32'(100 + i);
      tick();
    end
    d_push = 0;
    chk("d_ovf_level", d_level, 16);
    chk("d_ovf_err", err, 3'b010);
    data_rd_acq = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("d_ovf_rd_%0d", i), data_rd_data, 100 + i);
      tick();
    end
    data_rd_acq = 0;
    chk("d_ovf_empty", {data_rd_rdy, d_level}, 0);
    chk("d_ovf_err_end", err, 3'b010);

    // Simultaneous push and pop at level 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d_push = 1;
      d_wdata = i;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      d_push = 1;
      d_wdata = 8 + i;
      data_rd_acq = 1;
      chk($sformatf("d_pp_head_%0d", i), data_rd_data, i);
      tick();
      chk($sformatf("d_pp_level_%0d", i), d_level, 8);
    end
    d_push = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("d_pp_drain_%0d", i), data_rd_data, 4 + i);
      tick();
    end
    data_rd_acq = 0;
    chk("d_pp_err", err, 0);

    // Result FIFO fill, full stall, and release
    do_reset();
    dst_wr_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      result_addr = 4'(i);
      dst_wr_data = 32'h1000 + i;
      #1;
      chk($sformatf("r_acq_%0d", i), dst_wr_acq, 1);
      tick();
    end
    result_addr = 0;
    dst_wr_data = 32'h2000;
    chk("r_full_level", r_level, 16);
    chk("r_full_acq", dst_wr_acq, 0);
    tick();
    tick();
    chk("r_stall_level", r_level, 16);
    chk("r_stall_err", err, 0);
    chk("r_head0", r_rdata, {4'd0, 32'h1000});
    r_pop = 1;
    #1;
    chk("r_pop_acq_still0", dst_wr_acq, 0);
    tick();
    r_pop = 0;
    chk("r_pop_level", r_level, 15);
    chk("r_pop_acq_next", dst_wr_acq, 1);
    tick();
    dst_wr_rdy = 0;
    chk("r_refill_level", r_level, 16);
    chk("r_head1", r_rdata, {4'd1, 32'h1001});
    chk("r_refill_err", err, 0);

    // Sequence error at tag 3, then resync on tag 4
    do_reset();
    dst_wr_rdy = 1;
    result_addr = 0; dst_wr_data = 32'hA0; tick();
    result_addr = 1; dst_wr_data = 32'hA1; tick();
    chk("seq_ok_err", err, 0);
    result_addr = 3; dst_wr_data = 32'hA3; tick();
    chk("seq_bad_err", err, 3'b100);
    result_addr = 4; dst_wr_data = 32'hA4; tick();
    dst_wr_rdy = 0;
    chk("seq_resync_err", err, 3'b100);
    chk("seq_level", r_level, 4);
    r_pop = 1;
    chk("seq_head0", r_rdata, {4'd0, 32'hA0});
    tick();
    chk("seq_head1", r_rdata, {4'd1, 32'hA1});
    tick();
    chk("seq_head3", r_rdata, {4'd3, 32'hA3});
    tick();
    chk("seq_head4", r_rdata, {4'd4, 32'hA4});
    tick();
    r_pop = 0;
    chk("seq_empty", {r_valid, r_rdata}, 0);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w_push = 1;
      w_wdata = 32'h50 + i;
      tick();
    end
    w_push = 0;
    data_rd_acq = 1;
    tick();
    data_rd_acq = 0;
    chk("ar_pre_level", w_level, 5);
    chk("ar_pre_err", err, 3'b001);
    #2;
    counter_rst_n = 0;
    #1;
    chk("ar_w_level", w_level, 0);
    chk("ar_rdy", weight_rd_rdy, 0);
    chk("ar_err", err, 0);
    chk("ar_head", weight_rd_data, 0);
`ifdef PA_RESP_STATS_EN
    chk("ar_stats", {stat_w, stat_d, stat_r}, 0);
`endif
    #3;
    counter_rst_n = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
